reg_file_burst: RTL and testbench



---
 rtl/rf_pkg.sv | 23 ++
 rtl/rf_burst_ctrl.sv | 77 +++++++
 rtl/reg_file_burst.sv | 94 +++++++++
 tb/tb_reg_file_burst.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared defaults, register map and FSM state type for the burst register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rf_pkg;

   localparam int RF_WIDTH = 8;
   localparam int RF_DEPTH = 16;
   localparam int RF_ADDR  = 4;
   localparam int RF_BURST_W = 3;

   // Register map of the exported configuration words
   localparam int REG_ALU_A     = 0;
   localparam int REG_ALU_B     = 1;
   localparam int REG_UART_CFG  = 2;
   localparam int REG_DIV_RATIO = 3;

   // UART config: parity enable + prescale 32; divider ratio 32
   localparam logic [7:0] REG2_RST_DEF = 8'b1000_0001;
   localparam logic [7:0] REG3_RST_DEF = 8'd32;

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} rfState_t;

endpackage

// File: rtl/rf_burst_ctrl.sv
// Read sequencer: FSM, wrapping read pointer and remaining-beat counter.
// Latency: read address/take strobe combinational; valid strobe registered (1 cycle).
// Backpressure: none; RdEn during a burst is ignored, writes take priority in IDLE.
module rf_burst_ctrl
   import rf_pkg::*;
#(
   parameter int ADDR    = RF_ADDR,
   parameter int BURST_W = RF_BURST_W
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               WrEn,
   input  logic               RdEn,
   input  logic [ADDR-1:0]    Address,
   input  logic [BURST_W-1:0] BurstLen,
   output logic [ADDR-1:0]    rdAddr,
   output logic               rdTake,
   output logic               rdValid,
   output logic               Busy
);

   rfState_t           state, nextState;
   logic [ADDR-1:0]    ptr, nextPtr;
   logic [BURST_W-1:0] remaining, nextRemaining;

   // State, pointer, counter and valid strobe registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state     <= IDLE;
         ptr       <= '0;
         remaining <= '0;
         rdValid   <= 1'b0;
      end else begin
         state     <= nextState;
         ptr       <= nextPtr;
         remaining <= nextRemaining;
         rdValid   <= rdTake;
      end
   end

   // Next-state: start a read only when no write competes; a burst walks ptr until one beat is left
   always_comb begin
      nextState     = state;
      nextPtr       = ptr;
      nextRemaining = remaining;
      case (state)
         IDLE: begin
            if (RdEn && !WrEn) begin
               nextPtr       = Address + ADDR'(1);
               nextRemaining = BurstLen;
               if (BurstLen != '0) nextState = BURST;
            end
         end
         BURST: begin
            nextPtr       = ptr + ADDR'(1);
            nextRemaining = remaining - BURST_W'(1);
            if (remaining == BURST_W'(1)) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // Outputs: the first beat reads the request address directly, later beats read ptr
   always_comb begin
      rdAddr = Address;
      rdTake = 1'b0;
      Busy   = 1'b0;
      if (state == BURST) begin
         rdAddr = ptr;
         rdTake = 1'b1;
         Busy   = 1'b1;
      end else begin
         rdTake = RdEn && !WrEn;
      end
   end

endmodule

// File: rtl/reg_file_burst.sv
// DEPTH x WIDTH register file with single writes and wrapping burst reads; regs 0-3 exported.
// Latency: read data 1 cycle after RdEn; burst of N gives N back-to-back valid beats.
// Backpressure: none; optional write protection under macro RF_WR_PROTECT_EN (adds WP_MASK, WrErr).
module reg_file_burst
   import rf_pkg::*;
#(
   parameter int               WIDTH    = RF_WIDTH,
   parameter int               DEPTH    = RF_DEPTH,
   parameter int               ADDR     = RF_ADDR,
   parameter int               BURST_W  = RF_BURST_W,
   parameter logic [WIDTH-1:0] REG2_RST = WIDTH'(REG2_RST_DEF),
   parameter logic [WIDTH-1:0] REG3_RST = WIDTH'(REG3_RST_DEF)
`ifdef RF_WR_PROTECT_EN
   ,
   parameter logic [DEPTH-1:0] WP_MASK  = '0
`endif
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               WrEn,
   input  logic               RdEn,
   input  logic [ADDR-1:0]    Address,
   input  logic [WIDTH-1:0]   WrData,
   input  logic [BURST_W-1:0] BurstLen,
   output logic [WIDTH-1:0]   RdData,
   output logic               RdData_Valid,
   output logic               Busy,
`ifdef RF_WR_PROTECT_EN
   output logic               WrErr,
`endif
   output logic [WIDTH-1:0]   REG0,
   output logic [WIDTH-1:0]   REG1,
   output logic [WIDTH-1:0]   REG2,
   output logic [WIDTH-1:0]   REG3
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [ADDR-1:0]  rdAddr;
   logic             rdTake;
   logic             wrAccept;

   rf_burst_ctrl #(
      .ADDR    (ADDR),
      .BURST_W (BURST_W)
   ) uCtrl (
      .CLK      (CLK),
      .RST      (RST),
      .WrEn     (WrEn),
      .RdEn     (RdEn),
      .Address  (Address),
      .BurstLen (BurstLen),
      .rdAddr   (rdAddr),
      .rdTake   (rdTake),
      .rdValid  (RdData_Valid),
      .Busy     (Busy)
   );

`ifdef RF_WR_PROTECT_EN
   assign wrAccept = WrEn && !WP_MASK[Address];

   // One-cycle error pulse after a write that hit a protected address
   always_ff @(posedge CLK) begin
      if (!RST) WrErr <= 1'b0;
      else      WrErr <= WrEn && WP_MASK[Address];
   end
`else
   assign wrAccept = WrEn;
`endif

   // Storage: reset to the configuration defaults, otherwise accept writes in any FSM state
   always_ff @(posedge CLK) begin
      if (!RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i == REG_UART_CFG)       mem[i] <= REG2_RST;
            else if (i == REG_DIV_RATIO) mem[i] <= REG3_RST;
            else                         mem[i] <= '0;
         end
      end else if (wrAccept) begin
         mem[Address] <= WrData;
      end
   end

   // Read data register: samples the pre-write contents, so a same-cycle write is seen only later
   always_ff @(posedge CLK) begin
      if (!RST)        RdData <= '0;
      else if (rdTake) RdData <= mem[rdAddr];
   end

   assign REG0 = mem[REG_ALU_A];
   assign REG1 = mem[REG_ALU_B];
   assign REG2 = mem[REG_UART_CFG];
   assign REG3 = mem[REG_DIV_RATIO];

endmodule

// File: tb/tb_reg_file_burst.sv
// Directed bench for reg_file_burst with a queue-based reference model checked every cycle.
// Latency: n/a.
// Backpressure: n/a.
module tb_reg_file_burst;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       WrEn = 1'b0;
   logic       RdEn = 1'b0;
   logic [3:0] Address = '0;
   logic [7:0] WrData = '0;
   logic [2:0] BurstLen = '0;
   logic [7:0] RdData;
   logic       RdData_Valid;
   logic       Busy;
   logic [7:0] REG0, REG1, REG2, REG3;
`ifdef RF_WR_PROTECT_EN
   logic       WrErr;
`endif

   int checks = 0;
   int errors = 0;
   bit started = 1'b0;

   always #5 CLK = ~CLK;

   reg_file_burst #(
`ifdef RF_WR_PROTECT_EN
      .WP_MASK (16'h0008)
`endif
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .WrEn         (WrEn),
      .RdEn         (RdEn),
      .Address      (Address),
      .WrData       (WrData),
      .BurstLen     (BurstLen),
      .RdData       (RdData),
      .RdData_Valid (RdData_Valid),
      .Busy         (Busy),
`ifdef RF_WR_PROTECT_EN
      .WrErr        (WrErr),
`endif
      .REG0         (REG0),
      .REG1         (REG1),
      .REG2         (REG2),
      .REG3         (REG3)
   );

   // Reference model: memory array plus a queue of pending burst addresses
   logic [7:0] mdlMem [16];
   int         pend [$];
   logic [7:0] expData;
   logic       expValid;
   logic       expErr;
   logic [15:0] wpMask;

   initial begin
`ifdef RF_WR_PROTECT_EN
      wpMask = 16'h0008;
`else
      wpMask = 16'h0000;
`endif
   end

   always @(posedge CLK) begin
      if (!RST) begin
         for (int i = 0; i < 16; i++) mdlMem[i] = 8'h00;
         mdlMem[2] = 8'h81;
         mdlMem[3] = 8'd32;
         pend.delete();
         expData  = 8'h00;
         expValid = 1'b0;
         expErr   = 1'b0;
      end else begin
         if (pend.size() > 0) begin
            expData  = mdlMem[pend.pop_front()];
            expValid = 1'b1;
         end else if (RdEn && !WrEn) begin
            expData  = mdlMem[Address];
            expValid = 1'b1;
            for (int k = 1; k <= int'(BurstLen); k++) pend.push_back((int'(Address) + k) % 16);
         end else begin
            expValid = 1'b0;
         end
         expErr = WrEn && wpMask[Address];
         if (WrEn && !wpMask[Address]) mdlMem[Address] = WrData;
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge CLK) begin
      if (started) begin
         chk("model_valid", {7'd0, RdData_Valid}, {7'd0, expValid});
         chk("model_data", RdData, expData);
         chk("model_busy", {7'd0, Busy}, {7'd0, pend.size() > 0});
         chk("model_reg0", REG0, mdlMem[0]);
         chk("model_reg1", REG1, mdlMem[1]);
         chk("model_reg2", REG2, mdlMem[2]);
         chk("model_reg3", REG3, mdlMem[3]);
`ifdef RF_WR_PROTECT_EN
         chk("model_wrerr", {7'd0, WrErr}, {7'd0, expErr});
`endif
      end
   end

   // Apply one cycle of inputs and return at the following negedge
   task automatic drive(input logic wr, input logic rd, input logic [3:0] a,
                        input logic [7:0] d, input logic [2:0] bl);
      WrEn = wr; RdEn = rd; Address = a; WrData = d; BurstLen = bl;
      @(negedge CLK);
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 4'd0, 8'h00, 3'd0);
   endtask

   logic [7:0] burstExp [4];

   initial begin
      // 1: reset for two edges
      RST = 1'b0;
      @(negedge CLK);
      idle();
      started = 1'b1;
      chk("rst_reg0", REG0, 8'h00);
      chk("rst_reg1", REG1, 8'h00);
      chk("rst_reg2", REG2, 8'h81);
      chk("rst_reg3", REG3, 8'd32);
      chk("rst_valid", {7'd0, RdData_Valid}, 8'd0);
      chk("rst_busy", {7'd0, Busy}, 8'd0);
      RST = 1'b1;

      // 2: single write then single read
      drive(1'b1, 1'b0, 4'd5, 8'd10, 3'd0);
      drive(1'b0, 1'b1, 4'd5, 8'h00, 3'd0);
      chk("single_data", RdData, 8'd10);
      chk("single_valid", {7'd0, RdData_Valid}, 8'd1);
      chk("single_busy", {7'd0, Busy}, 8'd0);
      idle();
      chk("single_valid_drop", {7'd0, RdData_Valid}, 8'd0);
      chk("single_data_hold", RdData, 8'd10);

      // 3: wrapping 4-beat burst 14,15,0,1
      drive(1'b1, 1'b0, 4'd14, 8'hA0, 3'd0);
      drive(1'b1, 1'b0, 4'd15, 8'hA1, 3'd0);
      drive(1'b1, 1'b0, 4'd0,  8'hA2, 3'd0);
      drive(1'b1, 1'b0, 4'd1,  8'hA3, 3'd0);
      burstExp[0] = 8'hA0; burstExp[1] = 8'hA1; burstExp[2] = 8'hA2; burstExp[3] = 8'hA3;
      drive(1'b0, 1'b1, 4'd14, 8'h00, 3'd3);
      for (int b = 0; b < 4; b++) begin
         chk("burst_data", RdData, burstExp[b]);
         chk("burst_valid", {7'd0, RdData_Valid}, 8'd1);
         chk("burst_busy", {7'd0, Busy}, (b < 3) ? 8'd1 : 8'd0);
         idle();
      end
      chk("burst_end_valid", {7'd0, RdData_Valid}, 8'd0);

      // 4: write wins over a simultaneous read
      drive(1'b1, 1'b1, 4'd2, 8'd3, 3'd0);
      chk("wr_prio_valid", {7'd0, RdData_Valid}, 8'd0);
      chk("wr_prio_reg2", REG2, 8'd3);
      drive(1'b0, 1'b1, 4'd2, 8'h00, 3'd0);
      chk("wr_prio_read", RdData, 8'd3);

      // 5: write colliding with the burst pointer, plus an ignored mid-burst RdEn
      drive(1'b1, 1'b0, 4'd4, 8'h44, 3'd0);
      drive(1'b1, 1'b0, 4'd5, 8'h45, 3'd0);
      drive(1'b1, 1'b0, 4'd6, 8'h66, 3'd0);
      drive(1'b0, 1'b1, 4'd4, 8'h00, 3'd2);
      chk("coll_beat0", RdData, 8'h44);
      drive(1'b0, 1'b1, 4'd0, 8'h00, 3'd3);
      chk("coll_beat1", RdData, 8'h45);
      drive(1'b1, 1'b0, 4'd6, 8'h55, 3'd0);
      chk("coll_beat2_old", RdData, 8'h66);
      chk("coll_beat2_valid", {7'd0, RdData_Valid}, 8'd1);
      idle();
      chk("coll_no_extra", {7'd0, RdData_Valid}, 8'd0);
      chk("coll_busy_done", {7'd0, Busy}, 8'd0);
      drive(1'b0, 1'b1, 4'd6, 8'h00, 3'd0);
      chk("coll_new_value", RdData, 8'h55);

      // 6: reset in the second beat of a 4-beat burst
      drive(1'b0, 1'b1, 4'd8, 8'h00, 3'd3);
      idle();
      chk("rst_mid_beat2", {7'd0, RdData_Valid}, 8'd1);
      RST = 1'b0;
      idle();
      chk("rst_mid_valid", {7'd0, RdData_Valid}, 8'd0);
      chk("rst_mid_busy", {7'd0, Busy}, 8'd0);
      chk("rst_mid_reg2", REG2, 8'h81);
      RST = 1'b1;
      idle();

`ifdef RF_WR_PROTECT_EN
      drive(1'b1, 1'b0, 4'd3, 8'h07, 3'd0);
      chk("wp_reg3", REG3, 8'd32);
      chk("wp_err", {7'd0, WrErr}, 8'd1);
      idle();
      chk("wp_err_pulse", {7'd0, WrErr}, 8'd0);
`else
      drive(1'b1, 1'b0, 4'd3, 8'h07, 3'd0);
      chk("wr_reg3", REG3, 8'h07);
      idle();
`endif

      started = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
